// File: rtl/uart_tx_drain.sv
// Byte intake with one-cycle ack, small FIFO and 8N1 UART serializer for the debug dump path.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_AW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txValid,
  input  logic       notStartUartTrans,
  output logic       dataSent,
  output logic       tx,
  output logic       fifoEmpty,
  output logic       fifoFull,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]        BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   COUNT_ZERO = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  function automatic logic evenParity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_r;
  logic [FIFO_AW-1:0] rdPtr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   countNext_s;
  logic               push_s;
  logic               pop_s;
  logic               bitDone_s;
  logic               txBit_s;
  state_e             state_r;
  state_e             stateNext_s;
  logic [15:0]        baudCnt_r;
  logic [2:0]         bitIdx_r;
  logic [7:0]         shiftReg_r;
  logic               dataSent_r;
  logic               tx_r;
  logic               fifoEmpty_r;
  logic               fifoFull_r;
  logic               busy_r;

  assign dataSent  = dataSent_r;
  assign tx        = tx_r;
  assign fifoEmpty = fifoEmpty_r;
  assign fifoFull  = fifoFull_r;
  assign busy      = busy_r;

  // The ack term stops the same offered byte from being taken twice.
  assign push_s    = txValid & ~notStartUartTrans & ~fifoFull_r & ~dataSent_r;
  assign bitDone_s = (baudCnt_r == BAUD_LAST);

  // Occupancy after this cycle's push/pop
  always_comb begin
    countNext_s = count_r;
    case ({push_s, pop_s})
      2'b10:   countNext_s = count_r + COUNT_ONE;
      2'b01:   countNext_s = count_r - COUNT_ONE;
      default: countNext_s = count_r;
    endcase
  end

  // Serializer next state, head pop and line bit for the current state
  always_comb begin
    stateNext_s = state_r;
    pop_s       = 1'b0;
    txBit_s     = 1'b1;
    case (state_r)
      ST_IDLE: begin
        txBit_s = 1'b1;
        if (!fifoEmpty_r) begin
          pop_s       = 1'b1;
          stateNext_s = ST_START;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_START: begin
        txBit_s = 1'b0;
        if (bitDone_s) begin
          stateNext_s = ST_DATA;
        end else begin
          stateNext_s = ST_START;
        end
      end
      ST_DATA: begin
        txBit_s = shiftReg_r[bitIdx_r];
        if (bitDone_s && (bitIdx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          stateNext_s = ST_PARITY;
`else
          stateNext_s = ST_STOP;
`endif
        end else begin
          stateNext_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        txBit_s = evenParity(shiftReg_r);
        if (bitDone_s) begin
          stateNext_s = ST_STOP;
        end else begin
          stateNext_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        txBit_s = 1'b1;
        if (bitDone_s && !fifoEmpty_r) begin
          pop_s       = 1'b1;
          stateNext_s = ST_START;
        end else if (bitDone_s) begin
          stateNext_s = ST_IDLE;
        end else begin
          stateNext_s = ST_STOP;
        end
      end
      default: begin
        txBit_s     = 1'b1;
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage write; contents are don't-care until pushed
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wrPtr_r] <= txData;
    end
  end

  // FIFO pointers, occupancy, status flags and intake ack
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_r     <= '0;
      rdPtr_r     <= '0;
      count_r     <= '0;
      fifoEmpty_r <= 1'b1;
      fifoFull_r  <= 1'b0;
      dataSent_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      count_r     <= countNext_s;
      fifoEmpty_r <= (countNext_s == COUNT_ZERO);
      fifoFull_r  <= (countNext_s == COUNT_FULL);
      dataSent_r  <= push_s;
    end
  end

  // Serializer state, bit timing and registered line/busy outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baudCnt_r  <= 16'd0;
      bitIdx_r   <= 3'd0;
      shiftReg_r <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      // Restart bit timing on every state entry and at each bit boundary.
      if ((stateNext_s != state_r) || bitDone_s || (state_r == ST_IDLE)) begin
        baudCnt_r <= 16'd0;
      end else begin
        baudCnt_r <= baudCnt_r + 16'd1;
      end
      if (state_r != ST_DATA) begin
        bitIdx_r <= 3'd0;
      end else if (bitDone_s) begin
        bitIdx_r <= bitIdx_r + 3'd1;
      end
      if (pop_s) begin
        shiftReg_r <= mem_r[rdPtr_r];
      end
      tx_r   <= txBit_s;
      busy_r <= (stateNext_s != ST_IDLE) || (countNext_s != COUNT_ZERO);
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain (CLKS_PER_BIT=4, FIFO_AW=2) with an independent UART receiver model.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       notStartUartTrans = 1'b0;
  logic       dataSent, tx, fifoEmpty, fifoFull, busy;

  int errors = 0;
  int checks = 0;

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clock(clock), .reset(reset), .txData(txData), .txValid(txValid),
    .notStartUartTrans(notStartUartTrans), .dataSent(dataSent), .tx(tx),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .busy(busy)
  );

  always #5 clock = ~clock;

  // Receiver model: samples mid-bit on the falling edge
  logic [7:0] rxQ[$];
  int         startQ[$];
  int         cyc = 0, dsTotal = 0, txLowCnt = 0, frameErr = 0, parityErr = 0;
  int         dsAt[16];
  int         lastK;
  logic       full9;

  initial begin
    bit         rxActive;
    int         rxPos, rxStart;
    logic [7:0] rxByte;
    logic       rxPar;
    rxActive = 1'b0;
    rxPos = 0;
    rxStart = 0;
    rxByte = 8'h00;
    rxPar = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (dataSent === 1'b1) dsTotal++;
      if (tx === 1'b0) txLowCnt++;
      if (reset === 1'b1) begin
        rxActive = 1'b0;
      end else if (!rxActive) begin
        if (tx === 1'b0) begin
          rxActive = 1'b1;
          rxPos = 0;
          rxStart = cyc;
        end
      end else begin
        rxPos++;
        if ((rxPos % CPB) == CPB / 2) begin
          if (rxPos / CPB >= 1 && rxPos / CPB <= 8) rxByte[rxPos / CPB - 1] = tx;
          else if (rxPos / CPB == 9 && NBITS == 11) rxPar = tx;
          else if (rxPos / CPB == NBITS - 1) begin
            if (tx !== 1'b1) frameErr++;
            if (NBITS == 11 && rxPar !== ^rxByte) parityErr++;
            rxQ.push_back(rxByte);
            startQ.push_back(rxStart);
            rxActive = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle(input string tag);
    int w = 0;
    while (busy !== 1'b0 && w < 2000) begin
      tick();
      w++;
    end
    check(tag, busy, 0);
  endtask

  task automatic waitRx(input int n, input string tag);
    int w = 0;
    while (rxQ.size() < n && w < 2000) begin
      tick();
      w++;
    end
    check(tag, rxQ.size(), n);
  endtask

  // Held-valid upstream: advance txData on each ack, drop valid after n acks
  task automatic streamBytes(input logic [7:0] first, input int n, input int maxK);
    int k = 0, cnt = 0;
    full9 = 1'b0;
    txData = first;
    txValid = 1'b1;
    while (cnt < n && k < maxK) begin
      tick();
      k++;
      if (k == 9) full9 = fifoFull;
      if (dataSent === 1'b1) begin
        dsAt[cnt] = k;
        cnt++;
        txData = txData + 8'd1;
        if (cnt == n) txValid = 1'b0;
      end
    end
    txValid = 1'b0;
    check("stream ack count", cnt, n);
    lastK = k;
  endtask

  task automatic checkFrames(input logic [7:0] first, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i < rxQ.size()) check({tag, " byte"}, rxQ[i], first + 8'(i));
      if (i > 0 && i < startQ.size()) check({tag, " gap"}, startQ[i] - startQ[i-1], FRAME);
    end
  endtask

  initial begin
    int n, ds0, low0;

    // Reset state
    repeat (3) tick();
    check("reset tx", tx, 1);
    check("reset dataSent", dataSent, 0);
    check("reset fifoEmpty", fifoEmpty, 1);
    check("reset fifoFull", fifoFull, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: ack, pop and start-bit latency, frame length
    rxQ.delete(); startQ.delete();
    ds0 = dsTotal;
    txData = 8'hA5;
    txValid = 1'b1;
    tick();
    txValid = 1'b0;
    check("single ack", dataSent, 1);
    check("single notEmpty", fifoEmpty, 0);
    check("single busy", busy, 1);
    tick();
    check("single ack ends", dataSent, 0);
    check("single popped", fifoEmpty, 1);
    check("single tx before start", tx, 1);
    tick();
    check("single start bit", tx, 0);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("single busy fall", n, FRAME - 1);
    check("single ack pulses", dsTotal - ds0, 1);
    waitRx(1, "single frames");
    checkFrames(8'hA5, 1, "single");

    // Held valid: 0x01..0x06, ack every 2nd cycle, stall on full
    rxQ.delete(); startQ.delete();
    streamBytes(8'h01, 6, 200);
    for (int i = 0; i < 5; i++) check("held ack spacing", dsAt[i], 2 * i + 1);
    check("held full", full9, 1);
    check("held stall release", dsAt[5], FRAME + 3);
    waitRx(6, "held frames");
    checkFrames(8'h01, 6, "held");
    waitIdle("held idle");

    // Hold-off
    rxQ.delete(); startQ.delete();
    ds0 = dsTotal;
    low0 = txLowCnt;
    notStartUartTrans = 1'b1;
    txValid = 1'b1;
    txData = 8'h3C;
    repeat (20) tick();
    check("holdoff no ack", dsTotal - ds0, 0);
    check("holdoff tx idle", txLowCnt - low0, 0);
    check("holdoff empty", fifoEmpty, 1);
    notStartUartTrans = 1'b0;
    tick();
    txValid = 1'b0;
    check("holdoff release ack", dataSent, 1);
    waitRx(1, "holdoff frames");
    checkFrames(8'h3C, 1, "holdoff");
    waitIdle("holdoff idle");

    // Reset during bit 3 of 0xFF with two bytes queued
    rxQ.delete(); startQ.delete();
    streamBytes(8'hFF, 3, 50);
    repeat (19 - lastK) tick();
    check("midreset queued", fifoEmpty, 0);
    check("midreset busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset tx", tx, 1);
    check("midreset flushed", fifoEmpty, 1);
    check("midreset busy clr", busy, 0);
    ds0 = dsTotal;
    low0 = txLowCnt;
    repeat (3 * FRAME) tick();
    check("midreset no frames", rxQ.size(), 0);
    check("midreset tx quiet", txLowCnt - low0, 0);
    check("midreset no ack", dsTotal - ds0, 0);

    // Pointer wrap: 9 bytes through a 4-deep FIFO
    rxQ.delete(); startQ.delete();
    streamBytes(8'h10, 9, 1000);
    waitRx(9, "wrap frames");
    checkFrames(8'h10, 9, "wrap");
    waitIdle("wrap idle");
    repeat (2 * FRAME) tick();
    check("wrap no extra", rxQ.size(), 9);
    check("framing errors", frameErr, 0);
    check("parity errors", parityErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
